// File: rtl/player_state_controller.sv
// Per-player action/physics FSM: walking, jumping, crouching, attacks and stun.
// Updates once per rising edge of gameTicks; all outputs are registered.
module player_state_controller #(
    parameter int X_START    = 160,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 600,
    parameter int WALK_STEP  = 4,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int ATK1_TICKS = 6,
    parameter int ATK2_TICKS = 10,
    parameter int ATK3_TICKS = 16,
    parameter int STUN_TICKS = 20,
    parameter bit FACE_RIGHT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gameTicks,
    input  logic       movingLeft,
    input  logic       movingRight,
    input  logic       isCrouching,
    input  logic       isJumping,
    input  logic       isBlocking,
    input  logic [1:0] comboMove,
    input  logic       hitReceived,
    output logic [9:0] posX,
    output logic [7:0] posY,
    output logic       facingRight,
    output logic       isCrouched,
    output logic       isInAir,
    output logic       isStunned,
    output logic       isPerformingAttackAnimation,
    output logic [1:0] activeAttack,
    output logic       blockedHit
);

    typedef enum logic [2:0] {S_IDLE, S_CROUCH, S_JUMP, S_ATTACK, S_STUN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  posX_q, posX_d;
    logic [7:0]  posY_q, posY_d;
    logic [7:0]  vy_q, vy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        face_q, face_d;
    logic [1:0]  atk_q, atk_d;
    logic        hitPend_q, hitPend_d;
    logic        ticks_q;
    logic        blk_d;
    logic        crouched_q, inAir_q, stunned_q, attacking_q, blk_q;

    logic        tick, hit, phys, landed, walk_en;
    logic [9:0]  sum;
    logic [9:0]  walk_x;
    logic [4:0]  atk_ticks;

    assign tick    = gameTicks & ~ticks_q;
    assign hit     = hitPend_q | hitReceived;
    assign phys    = (state_q == S_JUMP) || ((state_q == S_STUN) && (posY_q != '0));
    // Signed 10-bit height/velocity sum so a downward step past ground is detectable
    assign sum     = {2'b00, posY_q} + {{2{vy_q[7]}}, vy_q};
    assign walk_en = movingLeft ^ movingRight;

    always_comb begin
        walk_x = posX_q;
        if (movingLeft) begin
            if (int'(posX_q) - WALK_STEP < X_MIN) walk_x = 10'(X_MIN);
            else                                  walk_x = posX_q - 10'(WALK_STEP);
        end else begin
            if (int'(posX_q) + WALK_STEP > X_MAX) walk_x = 10'(X_MAX);
            else                                  walk_x = posX_q + 10'(WALK_STEP);
        end
    end

    always_comb begin
        case (comboMove)
            2'd1:    atk_ticks = 5'(ATK1_TICKS);
            2'd2:    atk_ticks = 5'(ATK2_TICKS);
            default: atk_ticks = 5'(ATK3_TICKS);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        posX_d    = posX_q;
        posY_d    = posY_q;
        vy_d      = vy_q;
        cnt_d     = cnt_q;
        face_d    = face_q;
        atk_d     = atk_q;
        blk_d     = 1'b0;
        landed    = 1'b0;
        hitPend_d = hit;
        if (tick) begin
            hitPend_d = 1'b0;
            if (phys) begin
                if (sum[9] || (sum == '0)) begin
                    posY_d = '0;
                    vy_d   = '0;
                    landed = 1'b1;
                end else begin
                    posY_d = sum[7:0];
                    vy_d   = vy_q - 8'(GRAVITY);
                end
            end
            if (hit) begin
                if (isBlocking && ((state_q == S_IDLE) || (state_q == S_CROUCH))) begin
                    blk_d = 1'b1;
                end else begin
                    state_d = S_STUN;
                    cnt_d   = 5'(STUN_TICKS);
                    atk_d   = '0;
                end
            end else begin
                case (state_q)
                    S_IDLE, S_CROUCH: begin
                        if (comboMove != '0) begin
                            state_d = S_ATTACK;
                            cnt_d   = atk_ticks;
                            atk_d   = comboMove;
                        end else if (state_q == S_CROUCH) begin
                            if (!isCrouching) state_d = S_IDLE;
                        end else if (isJumping) begin
                            state_d = S_JUMP;
                            vy_d    = 8'(JUMP_VEL);
                        end else if (isCrouching) begin
                            state_d = S_CROUCH;
                        end else if (walk_en) begin
                            posX_d = walk_x;
                            face_d = movingRight;
                        end
                    end
                    S_JUMP: begin
                        if (walk_en) begin
                            posX_d = walk_x;
                            face_d = movingRight;
                        end
                        if (landed) state_d = S_IDLE;
                    end
                    S_ATTACK: begin
                        if (cnt_q <= 5'd1) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            atk_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 5'd1;
                        end
                    end
                    S_STUN: begin
                        // Exit waits for the landed height, so an airborne stun holds at zero
                        if (cnt_q <= 5'd1) begin
                            cnt_d = '0;
                            if (posY_d == '0) state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - 5'd1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            posX_q      <= 10'(X_START);
            posY_q      <= '0;
            vy_q        <= '0;
            cnt_q       <= '0;
            face_q      <= FACE_RIGHT;
            atk_q       <= '0;
            hitPend_q   <= 1'b0;
            ticks_q     <= 1'b0;
            crouched_q  <= 1'b0;
            inAir_q     <= 1'b0;
            stunned_q   <= 1'b0;
            attacking_q <= 1'b0;
            blk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            posX_q      <= posX_d;
            posY_q      <= posY_d;
            vy_q        <= vy_d;
            cnt_q       <= cnt_d;
            face_q      <= face_d;
            atk_q       <= atk_d;
            hitPend_q   <= hitPend_d;
            ticks_q     <= gameTicks;
            crouched_q  <= (state_d == S_CROUCH);
            inAir_q     <= (posY_d != '0) || (state_d == S_JUMP);
            stunned_q   <= (state_d == S_STUN);
            attacking_q <= (state_d == S_ATTACK);
            blk_q       <= blk_d;
        end
    end

    assign posX                        = posX_q;
    assign posY                        = posY_q;
    assign facingRight                 = face_q;
    assign isCrouched                  = crouched_q;
    assign isInAir                     = inAir_q;
    assign isStunned                   = stunned_q;
    assign isPerformingAttackAnimation = attacking_q;
    assign activeAttack                = atk_q;
    assign blockedHit                  = blk_q;

endmodule

// File: tb/tb_player_state_controller.sv
// Self-checking bench for player_state_controller: directed scenarios plus
// randomized ticks compared against a behavioural model of the game rules.
module tb_player_state_controller;

    localparam int XS = 162;

    logic       clk = 1'b0;
    logic       reset, gameTicks, movingLeft, movingRight, isCrouching, isJumping, isBlocking, hitReceived;
    logic [1:0] comboMove;
    logic [9:0] posX;
    logic [7:0] posY;
    logic       facingRight, isCrouched, isInAir, isStunned, isPerformingAttackAnimation, blockedHit;
    logic [1:0] activeAttack;

    player_state_controller #(.X_START(XS)) dut (
        .clk(clk), .reset(reset), .gameTicks(gameTicks),
        .movingLeft(movingLeft), .movingRight(movingRight),
        .isCrouching(isCrouching), .isJumping(isJumping), .isBlocking(isBlocking),
        .comboMove(comboMove), .hitReceived(hitReceived),
        .posX(posX), .posY(posY), .facingRight(facingRight),
        .isCrouched(isCrouched), .isInAir(isInAir), .isStunned(isStunned),
        .isPerformingAttackAnimation(isPerformingAttackAnimation),
        .activeAttack(activeAttack), .blockedHit(blockedHit)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef enum {M_IDLE, M_CROUCH, M_JUMP, M_ATTACK, M_STUN} mstate_t;
    mstate_t m_st;
    int      m_x, m_y, m_vy, m_cnt, m_atk;
    bit      m_face, m_blk, m_hitp;

    logic [25:0] obs;
    assign obs = {posX, posY, facingRight, isCrouched, isInAir, isStunned,
                  isPerformingAttackAnimation, activeAttack, blockedHit};

    function automatic logic [25:0] expv();
        return {10'(m_x), 8'(m_y), m_face, m_st == M_CROUCH, (m_y != 0) || (m_st == M_JUMP),
                m_st == M_STUN, m_st == M_ATTACK, 2'(m_atk), m_blk};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_x = XS; m_y = 0; m_vy = 0; m_cnt = 0; m_atk = 0;
        m_face = 1'b1; m_blk = 1'b0; m_hitp = 1'b0;
    endtask

    task automatic model_walk();
        if (movingLeft ^ movingRight) begin
            if (movingLeft) begin m_x = (m_x - 4 < 0) ? 0 : m_x - 4;       m_face = 1'b0; end
            else            begin m_x = (m_x + 4 > 600) ? 600 : m_x + 4;   m_face = 1'b1; end
        end
    endtask

    task automatic model_tick();
        bit hit, landed;
        int len;
        hit = m_hitp; m_hitp = 1'b0; m_blk = 1'b0; landed = 1'b0;
        if (m_st == M_JUMP || (m_st == M_STUN && m_y > 0)) begin
            if (m_y + m_vy <= 0) begin m_y = 0; m_vy = 0; landed = 1'b1; end
            else begin m_y = m_y + m_vy; m_vy = m_vy - 1; end
        end
        if (hit) begin
            if (isBlocking && (m_st == M_IDLE || m_st == M_CROUCH)) m_blk = 1'b1;
            else begin m_st = M_STUN; m_cnt = 20; m_atk = 0; end
        end else if ((m_st == M_IDLE || m_st == M_CROUCH) && comboMove != 0) begin
            len = (comboMove == 1) ? 6 : (comboMove == 2) ? 10 : 16;
            m_st = M_ATTACK; m_cnt = len; m_atk = int'(comboMove);
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (isJumping)        begin m_st = M_JUMP; m_vy = 12; end
                    else if (isCrouching) m_st = M_CROUCH;
                    else                  model_walk();
                end
                M_CROUCH: if (!isCrouching) m_st = M_IDLE;
                M_JUMP: begin
                    model_walk();
                    if (landed) m_st = M_IDLE;
                end
                M_ATTACK: begin
                    if (m_cnt <= 1) begin m_st = M_IDLE; m_cnt = 0; m_atk = 0; end
                    else m_cnt = m_cnt - 1;
                end
                default: begin
                    if (m_cnt <= 1) begin m_cnt = 0; if (m_y == 0) m_st = M_IDLE; end
                    else m_cnt = m_cnt - 1;
                end
            endcase
        end
    endtask

    task automatic set_in(input bit l, input bit r, input bit c, input bit j, input bit b, input logic [1:0] cm);
        movingLeft = l; movingRight = r; isCrouching = c; isJumping = j; isBlocking = b; comboMove = cm;
    endtask

    task automatic do_tick();
        @(negedge clk) gameTicks = 1'b1;
        model_tick();
        @(negedge clk) gameTicks = 1'b0;
    endtask

    task automatic pulse_hit();
        @(negedge clk) hitReceived = 1'b1;
        m_hitp = 1'b1;
        @(negedge clk) hitReceived = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; model_reset();
        @(negedge clk);
        total++; if (obs !== expv()) $display("FAIL reset: got %h expected %h", obs, expv()); else passed++;
        reset = 1'b0;
        set_in(0, 0, 0, 1, 0, 2'd0);
        do_tick();
        set_in(0, 0, 0, 0, 0, 2'd0);
        repeat (4) do_tick();
        total++; if (obs !== expv()) $display("FAIL pre_reset_jump: got %h expected %h", obs, expv()); else passed++;
        @(negedge clk) reset = 1'b1; model_reset();
        @(negedge clk);
        total++; if (obs !== expv()) $display("FAIL reset_midair: got %h expected %h", obs, expv()); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_walk_bounds();
        set_in(1, 0, 0, 0, 0, 2'd0);
        repeat (42) begin
            do_tick();
            total++; if (obs !== expv()) $display("FAIL walk_left: got %h expected %h", obs, expv()); else passed++;
        end
        total++;
        if (posX !== 10'd0 || facingRight !== 1'b0) $display("FAIL left_bound: got posX=%0d face=%b expected 0/0", posX, facingRight);
        else passed++;
        set_in(0, 1, 0, 0, 0, 2'd0);
        repeat (155) begin
            do_tick();
            total++; if (obs !== expv()) $display("FAIL walk_right: got %h expected %h", obs, expv()); else passed++;
        end
        total++;
        if (posX !== 10'd600 || facingRight !== 1'b1) $display("FAIL right_bound: got posX=%0d face=%b expected 600/1", posX, facingRight);
        else passed++;
        set_in(1, 1, 0, 0, 0, 2'd0);
        do_tick();
        total++; if (obs !== expv()) $display("FAIL walk_both: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_jump();
        int peak = 0;
        set_in(0, 0, 0, 1, 0, 2'd0);
        do_tick();
        set_in(0, 0, 0, 0, 0, 2'd0);
        total++; if (obs !== expv()) $display("FAIL jump_start: got %h expected %h", obs, expv()); else passed++;
        for (int i = 0; i < 40 && m_st == M_JUMP; i++) begin
            do_tick();
            if (int'(posY) > peak) peak = int'(posY);
            total++; if (obs !== expv()) $display("FAIL jump_arc: got %h expected %h", obs, expv()); else passed++;
        end
        total++; if (peak != 78) $display("FAIL jump_peak: got %0d expected 78", peak); else passed++;
        total++;
        if (isInAir !== 1'b0 || posY !== 8'd0) $display("FAIL jump_landed: got inAir=%b posY=%0d expected 0/0", isInAir, posY);
        else passed++;
    endtask

    task automatic test_attack();
        int n = 0;
        set_in(0, 0, 0, 0, 0, 2'd2);
        for (int i = 0; i < 14; i++) begin
            do_tick();
            comboMove = 2'd0;
            total++; if (obs !== expv()) $display("FAIL attack_seq: got %h expected %h", obs, expv()); else passed++;
            if (isPerformingAttackAnimation === 1'b1 && activeAttack === 2'd2) n++;
        end
        total++; if (n != 10) $display("FAIL attack_len: got %0d expected 10", n); else passed++;
    endtask

    task automatic test_hit_in_attack();
        int n = 1;
        set_in(0, 0, 0, 0, 0, 2'd3);
        do_tick();
        comboMove = 2'd0;
        repeat (3) do_tick();
        pulse_hit();
        do_tick();
        total++;
        if (isStunned !== 1'b1 || activeAttack !== 2'd0 || isPerformingAttackAnimation !== 1'b0)
            $display("FAIL hit_abort: got stun=%b atk=%0d anim=%b expected 1/0/0", isStunned, activeAttack, isPerformingAttackAnimation);
        else passed++;
        for (int i = 0; i < 25; i++) begin
            do_tick();
            total++; if (obs !== expv()) $display("FAIL stun_seq: got %h expected %h", obs, expv()); else passed++;
            if (isStunned === 1'b1) n++;
        end
        total++; if (n != 20) $display("FAIL stun_len: got %0d expected 20", n); else passed++;
    endtask

    task automatic test_block_crouch();
        set_in(0, 0, 1, 0, 0, 2'd0);
        do_tick();
        isBlocking = 1'b1;
        pulse_hit();
        do_tick();
        total++; if (obs !== expv()) $display("FAIL block_model: got %h expected %h", obs, expv()); else passed++;
        total++;
        if (blockedHit !== 1'b1 || isCrouched !== 1'b1 || isStunned !== 1'b0)
            $display("FAIL block_pulse: got blk=%b crouch=%b stun=%b expected 1/1/0", blockedHit, isCrouched, isStunned);
        else passed++;
        @(negedge clk);
        total++; if (blockedHit !== 1'b0) $display("FAIL block_width: got %b expected 0", blockedHit); else passed++;
        m_blk = 1'b0;
        set_in(0, 0, 0, 0, 0, 2'd0);
        do_tick();
        total++; if (obs !== expv()) $display("FAIL uncrouch: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
                   ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
            if ($urandom_range(0, 7) == 0) begin
                pulse_hit();
                if ($urandom_range(0, 1) == 0) pulse_hit();
            end
            do_tick();
            total++; if (obs !== expv()) $display("FAIL random %0d: got %h expected %h", i, obs, expv()); else passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        gameTicks = 1'b0; hitReceived = 1'b0;
        set_in(0, 0, 0, 0, 0, 2'd0);
        test_reset();
        test_walk_bounds();
        test_jump();
        test_attack();
        test_hit_in_attack();
        test_block_crouch();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
